// File: rtl/fpu_pkg.sv
// fpu_pkg: status bit indices and the stored result record shared by the fpu result FIFO.
package fpu_pkg;
  localparam int ST_EXACT     = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_INEXACT   = 3;
  typedef struct packed {
    logic [3:0]  status;
    logic [31:0] data;
  } fpu_result_t;
endpackage

// File: rtl/fpu_result_fifo_if.sv
// fpu_result_fifo_if: producer/consumer/status bundle of the fpu result FIFO.
// Per-status counters exist only when FPU_RESULT_STATUS_CNT_EN is defined.
interface fpu_result_fifo_if #(parameter int DEPTH = 8, parameter int DROP_W = 8);
  localparam int CW = $clog2(DEPTH + 1);
  logic              res_valid_in;
  logic [31:0]       res_data_in;
  logic [3:0]        res_status_in;
  logic              rd_ready_in;
  logic              rd_valid_out;
  logic [31:0]       rd_data_out;
  logic [3:0]        rd_status_out;
  logic [CW-1:0]     count_out;
  logic              full_out;
  logic [DROP_W-1:0] drop_cnt_out;
  logic              drop_sticky_out;
`ifdef FPU_RESULT_STATUS_CNT_EN
  logic [15:0] exact_cnt_out, ovf_cnt_out, unf_cnt_out, inexact_cnt_out;
`endif
  modport slave (
    input  res_valid_in, res_data_in, res_status_in, rd_ready_in,
    output rd_valid_out, rd_data_out, rd_status_out, count_out, full_out,
           drop_cnt_out, drop_sticky_out
`ifdef FPU_RESULT_STATUS_CNT_EN
    , output exact_cnt_out, ovf_cnt_out, unf_cnt_out, inexact_cnt_out
`endif
  );
  modport master (
    output res_valid_in, res_data_in, res_status_in, rd_ready_in,
    input  rd_valid_out, rd_data_out, rd_status_out, count_out, full_out,
           drop_cnt_out, drop_sticky_out
`ifdef FPU_RESULT_STATUS_CNT_EN
    , input exact_cnt_out, ovf_cnt_out, unf_cnt_out, inexact_cnt_out
`endif
  );
endinterface

// File: rtl/fpu_result_fifo_mem.sv
// fpu_result_fifo_mem: DEPTH-entry result storage, registered write, asynchronous read.
module fpu_result_fifo_mem
  import fpu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  fpu_result_t   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fpu_result_t   rdata_o
);
  fpu_result_t mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo: buffers fpu results for a valid/ready consumer and counts overflow drops.
// Define FPU_RESULT_STATUS_CNT_EN to add saturating per-status-bit counters of accepted results.
module fpu_result_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic clock100KHz,
  input  logic reset,
  fpu_result_fifo_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              drop_sticky_q, drop_sticky_d;
  logic              full, push, pop, drop;
  fpu_result_t       wdata, head;
  assign full  = count_q == CW'(DEPTH);
  assign pop   = (count_q != '0) && f.rd_ready_in;
  // a pop frees the slot the same cycle, so a full FIFO still accepts the write
  assign push  = f.res_valid_in && (!full || pop);
  assign drop  = f.res_valid_in && full && !pop;
  assign wdata = '{status: f.res_status_in, data: f.res_data_in};
  fpu_result_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clock100KHz),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );
  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    drop_cnt_d    = (drop && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    drop_sticky_d = drop_sticky_q | drop;
  end
  always_ff @(posedge clock100KHz or negedge reset)
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      drop_cnt_q    <= '0;
      drop_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      drop_cnt_q    <= drop_cnt_d;
      drop_sticky_q <= drop_sticky_d;
    end
  // storage is not reset, so the head is masked to zero while empty
  assign f.rd_valid_out    = count_q != '0;
  assign f.rd_data_out     = f.rd_valid_out ? head.data : '0;
  assign f.rd_status_out   = f.rd_valid_out ? head.status : '0;
  assign f.count_out       = count_q;
  assign f.full_out        = full;
  assign f.drop_cnt_out    = drop_cnt_q;
  assign f.drop_sticky_out = drop_sticky_q;
`ifdef FPU_RESULT_STATUS_CNT_EN
  logic [3:0][15:0] st_cnt_q, st_cnt_d;
  always_comb begin
    st_cnt_d = st_cnt_q;
    for (int b = 0; b < 4; b++)
      st_cnt_d[b] = (push && f.res_status_in[b] && st_cnt_q[b] != '1) ? st_cnt_q[b] + 1'b1 : st_cnt_q[b];
  end
  always_ff @(posedge clock100KHz or negedge reset)
    if (!reset) st_cnt_q <= '0;
    else        st_cnt_q <= st_cnt_d;
  assign f.exact_cnt_out   = st_cnt_q[ST_EXACT];
  assign f.ovf_cnt_out     = st_cnt_q[ST_OVERFLOW];
  assign f.unf_cnt_out     = st_cnt_q[ST_UNDERFLOW];
  assign f.inexact_cnt_out = st_cnt_q[ST_INEXACT];
`endif
endmodule

// File: tb/tb_fpu_result_fifo.sv
// tb_fpu_result_fifo: directed and randomized checks of fpu_result_fifo against a queue model.
`timescale 1ns/1ps
module tb_fpu_result_fifo;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fpu_result_fifo_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) f();
  fpu_result_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (.clock100KHz(clk), .reset(rst_n), .f(f));
  always #5 clk = ~clk;
  logic [35:0] q[$];
  int m_drop, m_cnt[4], n_cmp, n_bad;
  bit m_sticky;
  task automatic model_clear();
    q.delete();
    m_drop = 0;
    m_sticky = 0;
    for (int b = 0; b < 4; b++) m_cnt[b] = 0;
  endtask
  // drive one clock of stimulus, then update the model to the post-edge state
  task automatic cycle(input bit v, input logic [31:0] d, input logic [3:0] s, input bit rdy);
    bit pop, push;
    f.res_valid_in = v;
    f.res_data_in = d;
    f.res_status_in = s;
    f.rd_ready_in = rdy;
    pop = rdy && q.size() > 0;
    push = v && (q.size() < DEPTH || pop);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back({s, d});
      for (int b = 0; b < 4; b++) if (s[b] && m_cnt[b] < 65535) m_cnt[b]++;
    end
    if (v && !push) begin
      m_drop = (m_drop < DROP_MAX) ? m_drop + 1 : DROP_MAX;
      m_sticky = 1;
    end
  endtask
  task automatic test_reset();
    f.res_valid_in = 0; f.res_data_in = '0; f.res_status_in = '0; f.rd_ready_in = 0;
    rst_n = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (f.rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", f.rd_valid_out); end
    n_cmp++; if (f.count_out !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", f.count_out); end
    n_cmp++; if (f.full_out !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", f.full_out); end
    n_cmp++; if (f.drop_cnt_out !== '0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", f.drop_cnt_out); end
    n_cmp++; if (f.drop_sticky_out !== 1'b0) begin n_bad++; $display("FAIL reset_sticky: got %b want 0", f.drop_sticky_out); end
    @(negedge clk);
    rst_n = 1;
    cycle(0, '0, '0, 1);
    n_cmp++; if (f.rd_valid_out !== 1'b0 || f.count_out !== '0) begin n_bad++; $display("FAIL idle: got valid %b count %0d want 0 0", f.rd_valid_out, f.count_out); end
  endtask
  task automatic test_single();
    cycle(1, 32'h3F800000, 4'b0001, 0);
    n_cmp++; if (f.rd_valid_out !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", f.rd_valid_out); end
    n_cmp++; if (f.rd_data_out !== 32'h3F800000) begin n_bad++; $display("FAIL single_data: got %h want 3f800000", f.rd_data_out); end
    n_cmp++; if (f.rd_status_out !== 4'b0001) begin n_bad++; $display("FAIL single_status: got %b want 0001", f.rd_status_out); end
    n_cmp++; if (f.count_out !== 4'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", f.count_out); end
    cycle(0, '0, '0, 1);
    n_cmp++; if (f.rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL single_pop: got valid %b want 0", f.rd_valid_out); end
    cycle(0, '0, '0, 1);
    n_cmp++; if (f.count_out !== 4'd0) begin n_bad++; $display("FAIL empty_ready: got count %0d want 0", f.count_out); end
  endtask
  task automatic test_fill_drop();
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'h40000000 + i, 4'b1000, 0);
    n_cmp++; if (f.full_out !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", f.full_out); end
    n_cmp++; if (f.count_out !== 4'd8) begin n_bad++; $display("FAIL fill_count: got %0d want 8", f.count_out); end
    cycle(1, 32'hDEADBEEF, 4'b0010, 0);
    n_cmp++; if (f.drop_cnt_out !== 8'd1) begin n_bad++; $display("FAIL drop_cnt: got %0d want 1", f.drop_cnt_out); end
    n_cmp++; if (f.drop_sticky_out !== 1'b1) begin n_bad++; $display("FAIL drop_sticky: got %b want 1", f.drop_sticky_out); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (f.rd_valid_out !== 1'b1 || f.rd_data_out !== 32'h40000000 + i) begin n_bad++; $display("FAIL drain_order[%0d]: got %b/%h want 1/%h", i, f.rd_valid_out, f.rd_data_out, 32'h40000000 + i); end
      cycle(0, '0, '0, 1);
    end
    n_cmp++; if (f.rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", f.rd_valid_out); end
  endtask
  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) cycle(1, $urandom, 4'($urandom), 0);
    cycle(1, 32'hCAFEF00D, 4'b0100, 1);
    n_cmp++; if (f.count_out !== 4'd8) begin n_bad++; $display("FAIL fpp_count: got %0d want 8", f.count_out); end
    n_cmp++; if (f.drop_cnt_out !== DROP_W'(m_drop)) begin n_bad++; $display("FAIL fpp_drop: got %0d want %0d", f.drop_cnt_out, m_drop); end
    while (q.size() > 1) begin
      n_cmp++; if ({f.rd_status_out, f.rd_data_out} !== q[0]) begin n_bad++; $display("FAIL fpp_drain: got %h want %h", {f.rd_status_out, f.rd_data_out}, q[0]); end
      cycle(0, '0, '0, 1);
    end
    n_cmp++; if (f.rd_data_out !== 32'hCAFEF00D || f.rd_status_out !== 4'b0100) begin n_bad++; $display("FAIL fpp_last: got %h/%b want cafef00d/0100", f.rd_data_out, f.rd_status_out); end
    cycle(0, '0, '0, 1);
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 60, $urandom, 4'($urandom), $urandom_range(0, 99) < 45);
      n_cmp++; if (f.count_out !== 4'(q.size()) || f.full_out !== (q.size() == DEPTH) || f.rd_valid_out !== (q.size() != 0)) begin n_bad++; $display("FAIL rand_flags[%0d]: got cnt %0d full %b valid %b want %0d", i, f.count_out, f.full_out, f.rd_valid_out, q.size()); end
      if (q.size() != 0) begin
        n_cmp++; if ({f.rd_status_out, f.rd_data_out} !== q[0]) begin n_bad++; $display("FAIL rand_head[%0d]: got %h want %h", i, {f.rd_status_out, f.rd_data_out}, q[0]); end
      end
      n_cmp++; if (f.drop_cnt_out !== DROP_W'(m_drop) || f.drop_sticky_out !== m_sticky) begin n_bad++; $display("FAIL rand_drop[%0d]: got %0d/%b want %0d/%b", i, f.drop_cnt_out, f.drop_sticky_out, m_drop, m_sticky); end
    end
  endtask
  task automatic test_saturate_async_reset();
    while (q.size() < DEPTH) cycle(1, $urandom, 4'b0001, 0);
    for (int i = 0; i < 300; i++) cycle(1, $urandom, 4'b0001, 0);
    n_cmp++; if (f.drop_cnt_out !== DROP_W'(DROP_MAX) || m_drop != DROP_MAX) begin n_bad++; $display("FAIL drop_sat: got %0d want %0d", f.drop_cnt_out, DROP_MAX); end
    f.res_valid_in = 1;
    #2;
    rst_n = 0;
    #1;
    model_clear();
    n_cmp++; if (f.rd_valid_out !== 1'b0 || f.full_out !== 1'b0 || f.count_out !== '0) begin n_bad++; $display("FAIL async_flags: got valid %b full %b count %0d want 0", f.rd_valid_out, f.full_out, f.count_out); end
    n_cmp++; if (f.drop_cnt_out !== '0 || f.drop_sticky_out !== 1'b0) begin n_bad++; $display("FAIL async_drop: got %0d/%b want 0/0", f.drop_cnt_out, f.drop_sticky_out); end
    n_cmp++; if (f.rd_data_out !== '0 || f.rd_status_out !== '0) begin n_bad++; $display("FAIL async_data: got %h/%b want 0/0", f.rd_data_out, f.rd_status_out); end
    f.res_valid_in = 0;
    @(negedge clk);
    rst_n = 1;
    cycle(0, '0, '0, 0);
    n_cmp++; if (f.rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL post_reset: got valid %b want 0", f.rd_valid_out); end
  endtask
`ifdef FPU_RESULT_STATUS_CNT_EN
  task automatic test_status_cnt();
    logic [3:0] st [4] = '{4'b0001, 4'b0010, 4'b0010, 4'b1000};
    for (int i = 0; i < 4; i++) cycle(1, $urandom, st[i], 1);
    n_cmp++; if (f.exact_cnt_out !== 16'd1 || m_cnt[0] != 1) begin n_bad++; $display("FAIL cnt_exact: got %0d want 1", f.exact_cnt_out); end
    n_cmp++; if (f.ovf_cnt_out !== 16'd2) begin n_bad++; $display("FAIL cnt_ovf: got %0d want 2", f.ovf_cnt_out); end
    n_cmp++; if (f.unf_cnt_out !== 16'd0) begin n_bad++; $display("FAIL cnt_unf: got %0d want 0", f.unf_cnt_out); end
    n_cmp++; if (f.inexact_cnt_out !== 16'd1) begin n_bad++; $display("FAIL cnt_inexact: got %0d want 1", f.inexact_cnt_out); end
    for (int i = 0; i < 60; i++) cycle($urandom_range(0, 1), $urandom, 4'($urandom), $urandom_range(0, 99) < 30);
    n_cmp++; if ({f.inexact_cnt_out, f.unf_cnt_out, f.ovf_cnt_out, f.exact_cnt_out} !== {16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])}) begin n_bad++; $display("FAIL cnt_rand: got %0d %0d %0d %0d want %0d %0d %0d %0d", f.exact_cnt_out, f.ovf_cnt_out, f.unf_cnt_out, f.inexact_cnt_out, m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]); end
  endtask
`endif
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_fill_drop();
    test_full_push_pop();
    test_random();
    test_saturate_async_reset();
`ifdef FPU_RESULT_STATUS_CNT_EN
    test_status_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fpu_result_fifo.md
Name: fpu_result_fifo

Overview:
- Downstream stage of the fpu: captures each completed result (32-bit data_out plus 4-bit status_out) into a small FIFO.
- Presents captured results to a consumer (display/UART/controller) over a valid/ready interface.
- Decouples fpu completion timing from consumer speed.
- Counts results dropped on overflow.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, >= 2
DROP_W, 8, width of the saturating drop counter

Ports:
clock100KHz  input  1  system clock, 100 kHz, rising-edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
res_valid_in  input  1  one-cycle strobe: fpu result valid this cycle
res_data_in  input  32  fpu data_out (IEEE-754 single)
res_status_in  input  4  fpu status_out, one-hot: [0] EXACT, [1] OVERFLOW, [2] UNDERFLOW, [3] INEXACT
rd_ready_in  input  1  consumer accepts head entry this cycle
rd_valid_out  output  1  head entry available
rd_data_out  output  32  head entry data
rd_status_out  output  4  head entry status
count_out  output  $clog2(DEPTH+1)  current occupancy
full_out  output  1  occupancy == DEPTH
drop_cnt_out  output  DROP_W  results lost while full, saturating
drop_sticky_out  output  1  set on first drop, cleared only by reset

Behaviour:
- Reset (reset == 0, async):
  - Pointers, count_out, drop_cnt_out and drop_sticky_out go to 0.
  - rd_valid_out = 0, full_out = 0.
  - rd_data_out = 0, rd_status_out = 0.
  - Storage contents are don't-care.
  - Reset mid-transfer discards all entries; no partial state survives.
- Push: res_valid_in == 1 and (not full, or pop in the same cycle).
  - Writes {status, data} at the write pointer.
  - Write pointer increments modulo DEPTH.
- Pop: rd_valid_out == 1 and rd_ready_in == 1.
  - Head is consumed; read pointer increments modulo DEPTH.
  - rd_ready_in while empty is ignored.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged. This includes the full case, where the write is accepted.
- Drop: res_valid_in == 1, full, and no pop in that cycle.
  - Data is discarded.
  - drop_cnt_out increments, saturating at 2^DROP_W - 1.
  - drop_sticky_out is set.
- Latency:
  - A push into an empty FIFO makes rd_valid_out = 1 on the next rising edge. There is no same-cycle bypass.
  - rd_data_out and rd_status_out show the head entry whenever rd_valid_out = 1 and are stable until popped.
- Derived flags:
  - rd_valid_out = (count != 0).
  - full_out = (count == DEPTH).
  - Both are driven from registered count; no combinational path from inputs.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are resolved by count, not by pointer compare.
- The block never alters data or status; a status value that is not one-hot is stored unchanged.

Optional Feature:
- Macro: FPU_RESULT_STATUS_CNT_EN
- Defined:
  - Adds four output ports: exact_cnt_out, ovf_cnt_out, unf_cnt_out, inexact_cnt_out, each 16 bits.
  - Each counter increments on every accepted push whose corresponding status bit is 1. A non-one-hot status increments each set bit.
  - Counters saturate at 0xFFFF, reset to 0, and ignore dropped results.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fpu_pkg:
  - Status bit index constants ST_EXACT = 0, ST_OVERFLOW = 1, ST_UNDERFLOW = 2, ST_INEXACT = 3.
  - typedef fpu_result_t: packed struct {logic [3:0] status; logic [31:0] data}.
- One sub-module, fpu_result_fifo_mem: DEPTH x 36-bit storage with a registered write port and an asynchronous read at the read pointer.
- Control logic (pointers, count, drop logic, optional counters) stays in fpu_result_fifo.

Test Plan:
- Reset then idle -> rd_valid_out = 0, count_out = 0, full_out = 0, drop_cnt_out = 0.
- Push data 0x3F800000 with status 0001 while rd_ready_in = 0 -> next edge: rd_valid_out = 1, rd_data_out = 0x3F800000, rd_status_out = 0001, count_out = 1; raising rd_ready_in for one cycle -> rd_valid_out = 0.
- Push 8 results 0x40000000 + i (i = 0..7) with no reads -> full_out = 1, count_out = 8; 9th push -> drop_cnt_out = 1, drop_sticky_out = 1; drain -> data out in order 0x40000000..0x40000007.
- While full, push and pop in the same cycle -> count_out stays 8, drop_cnt_out unchanged, new entry appears last after drain.
- 300 pushes while full with no pops -> drop_cnt_out saturates at 255; reset (reset = 0) mid-stream -> all outputs return to 0 immediately, without waiting for a clock edge.
- With FPU_RESULT_STATUS_CNT_EN defined, push statuses 0001, 0010, 0010, 1000 -> exact = 1, ovf = 2, unf = 0, inexact = 1.
